// File: rtl/regfile_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : regfile_pkg                                                   |
// | Purpose  : Shared types and helpers for the multi-read-port register     |
// |            file: controller state encoding, byte width, lane merge.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
package regfile_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_READY = 1'b1
   } rf_state_e;

   // Single byte-lane merge: the enabled lane takes the new byte, otherwise
   // the stored byte is kept. Used for both the write path and the bypass.
   function automatic logic [BYTE_W-1:0] rf_merge(
      input logic [BYTE_W-1:0] old_b,
      input logic [BYTE_W-1:0] new_b,
      input logic              be
   );
      return be ? new_b : old_b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : regfile_rd_port                                               |
// | Purpose  : One read port: address range check, write-to-read bypass     |
// |            merge, optional output register.                              |
// | Ports    : clk       clock                                               |
// |            i_ready   controller ready and not in reset                   |
// |            i_re      read request                                        |
// |            i_raddr   read address                                        |
// |            i_mem     storage array contents                              |
// |            i_wr_ok   an in-range write is being accepted this cycle      |
// |            i_waddr / i_wdata / i_wbe   the accepted write                |
// |            o_rdata / o_rvalid          read result                       |
// |            o_oor     request served this cycle addresses >= DEPTH        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int RD_REG = 1,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              i_ready,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   input  logic [DATA_W-1:0] i_mem [DEPTH],
   input  logic              i_wr_ok,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W/BYTE_W-1:0] i_wbe,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   output logic              o_oor
);

   localparam int              c_NB    = DATA_W / BYTE_W;
   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

   logic              w_inr;
   logic              w_hit;
   logic              w_srv;
   logic [DATA_W-1:0] w_val;

   assign w_inr = ({1'b0, i_raddr} < c_DEPTH);
   assign w_hit = (BYPASS != 0) && i_wr_ok && (i_waddr == i_raddr);
   assign w_srv = i_ready && i_re;
   assign o_oor = w_srv && !w_inr;

   // Out-of-range reads return zero; a same-cycle write to the address is
   // merged per lane so the reader sees the post-write value.
   always_comb begin
      w_val = '0;
      if (w_inr) begin
         w_val = i_mem[i_raddr];
         if (w_hit) begin
            for (int b = 0; b < c_NB; b++) begin
               w_val[b*BYTE_W +: BYTE_W] = rf_merge(w_val[b*BYTE_W +: BYTE_W],
                                                    i_wdata[b*BYTE_W +: BYTE_W],
                                                    i_wbe[b]);
            end
         end
      end
   end

   generate
      if (RD_REG != 0) begin : g_reg
         logic [DATA_W-1:0] r_rdata;
         logic              r_rvalid;

         // Not ready covers both reset and the clear sweep: outputs are zero.
         always_ff @(posedge clk) begin
            if (!i_ready) begin
               r_rdata  <= '0;
               r_rvalid <= 1'b0;
            end else begin
               r_rvalid <= i_re;
               if (i_re) begin
                  r_rdata <= w_val;
               end
            end
         end

         assign o_rdata  = r_rdata;
         assign o_rvalid = r_rvalid;
      end else begin : g_comb
         assign o_rvalid = w_srv;
         assign o_rdata  = w_srv ? w_val : '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : regfile_mp                                                    |
// | Purpose  : Parametrised register file with NUM_RD read ports, byte-lane  |
// |            write enables, optional bypass and registered reads, and a    |
// |            one-entry-per-cycle clear sweep after reset.                  |
// | Ports    : clk, srst        clock, synchronous active-high reset         |
// |            we/waddr/wdata/wbe   write request                            |
// |            re/raddr         per-port read request, packed addresses      |
// |            rdata/rvalid     per-port read data and valid, packed         |
// |            busy             clear sweep running (or reset held)          |
// |            oor_err          one-cycle pulse, accepted access >= DEPTH    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 8,
   parameter  int NUM_RD = 2,
   parameter  int RD_REG = 1,
   parameter  int BYPASS = 1,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int NB     = DATA_W / BYTE_W
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [NB-1:0]            wbe,
   input  logic [NUM_RD-1:0]        re,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rvalid,
   output logic                     busy,
   output logic                     oor_err
);

   localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);

   rf_state_e         r_state;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_oor;

   logic              w_ready;
   logic              w_clr_wr;
   logic              w_wr_inr;
   logic              w_wr_ok;
   logic              w_wr_oor;
   logic [NUM_RD-1:0] w_rd_oor;

   assign w_ready  = (r_state == RF_READY) && !srst;
   assign w_clr_wr = (r_state == RF_CLEAR) && !srst;
   assign w_wr_inr = ({1'b0, waddr} < c_DEPTH);
   assign w_wr_ok  = w_ready && we && w_wr_inr;
   assign w_wr_oor = w_ready && we && !w_wr_inr;
   assign busy     = srst || (r_state == RF_CLEAR);
   assign oor_err  = r_oor;

   // Clear controller: entry clr_cnt is zeroed each cycle while clearing;
   // READY follows the cycle that clears the last entry.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_state   <= RF_CLEAR;
         r_clr_cnt <= '0;
      end else if (r_state == RF_CLEAR) begin
         if (r_clr_cnt == c_LAST) begin
            r_state <= RF_READY;
         end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
         end
      end
   end

   // Storage has no reset of its own; the sweep owns the write port while
   // clearing, so host writes cannot land during that window.
   always_ff @(posedge clk) begin
      if (w_clr_wr) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_ok) begin
         for (int b = 0; b < NB; b++) begin
            r_mem[waddr][b*BYTE_W +: BYTE_W] <= rf_merge(r_mem[waddr][b*BYTE_W +: BYTE_W],
                                                         wdata[b*BYTE_W +: BYTE_W],
                                                         wbe[b]);
         end
      end
   end

   // Registered for every RD_REG setting so the error has a single timing.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_oor <= 1'b0;
      end else begin
         r_oor <= w_wr_oor || (|w_rd_oor);
      end
   end

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
         regfile_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .RD_REG (RD_REG),
            .BYPASS (BYPASS)
         ) u_rd_port (
            .clk      (clk),
            .i_ready  (w_ready),
            .i_re     (re[p]),
            .i_raddr  (raddr[p*ADDR_W +: ADDR_W]),
            .i_mem    (r_mem),
            .i_wr_ok  (w_wr_ok),
            .i_waddr  (waddr),
            .i_wdata  (wdata),
            .i_wbe    (wbe),
            .o_rdata  (rdata[p*DATA_W +: DATA_W]),
            .o_rvalid (rvalid[p]),
            .o_oor    (w_rd_oor[p])
         );
      end
   endgenerate

endmodule
`default_nettype wire
